// File: rtl/mem_responder.sv
// mem_responder: single-request RAM responder with programmable wait states, one-cycle ack and error pulse.
module mem_responder #(
    parameter int N           = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [N-1:0]      data_wr,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic [N-1:0]      data_rd,
    output logic              mem_ack,
    output logic              busy,
    output logic              err
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, a_addr;
    logic [N-1:0]      data_q, data_d, data_rd_q, data_rd_d, a_data;
    logic              op_q, op_d, err_q, err_d, a_wr, a_in, access;
    logic [N-1:0]      mem [DEPTH];
    // With zero wait states the access happens at the accept edge, so it uses the live request.
    assign a_addr = state_q == IDLE ? addr : addr_q;
    assign a_data = state_q == IDLE ? data_wr : data_q;
    assign a_wr   = state_q == IDLE ? wr_req : op_q;
    assign a_in   = 32'(a_addr) < DEPTH;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        op_d      = op_q;
        data_rd_d = data_rd_q;
        err_d     = 1'b0;
        access    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req ^ wr_req) begin
                    addr_d  = addr;
                    data_d  = data_wr;
                    op_d    = wr_req;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = WAIT_CYCLES == 0 ? ACK : WAIT;
                    access  = WAIT_CYCLES == 0;
                end else if (rd_req && wr_req) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACK;
                    access  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (access) begin
            err_d = !a_in;
            if (!a_wr) data_rd_d = a_in ? mem[a_addr[AW-1:0]] : '0;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            op_q      <= 1'b0;
            data_rd_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            op_q      <= op_d;
            data_rd_q <= data_rd_d;
            err_q     <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (access && a_wr && a_in) mem[a_addr[AW-1:0]] <= a_data;
    end
    assign data_rd = data_rd_q;
    assign mem_ack = state_q == ACK;
    assign busy    = state_q != IDLE;
    assign err     = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (DEPTH=200, WAIT_CYCLES=2).
module tb_mem_responder;
    logic       clk = 1'b0, rst = 1'b0;
    logic [7:0] addr = '0, data_wr = '0;
    logic       rd_req = 1'b0, wr_req = 1'b0;
    logic [7:0] data_rd;
    logic       mem_ack, busy, err;
    int         checks = 0, errors = 0;
    typedef struct packed {logic [7:0] d; logic e;} exp_t;
    exp_t       sb[$];
    logic [7:0] model[256];
    logic [7:0] rd_model = '0;
    int         lat;

    always #5 clk = ~clk;

    mem_responder #(.N(8), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_wr(data_wr), .rd_req(rd_req),
        .wr_req(wr_req), .data_rd(data_rd), .mem_ack(mem_ack), .busy(busy), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [7:0] a, input logic [7:0] d);
        exp_t x;
        if (!wr) rd_model = a < 8'd200 ? model[a] : 8'h00;
        else if (a < 8'd200) model[a] = d;
        x.d = rd_model;
        x.e = a >= 8'd200;
        sb.push_back(x);
    endtask

    // Waits for the next ack (bounded), compares it against the scoreboard head and returns the cycle count.
    task automatic ack_wait(input string tag, input logic chk_busy, input logic scramble, output int l);
        exp_t x;
        l = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (mem_ack) begin
                l = i;
                break;
            end
            if (chk_busy) check({tag, " busy"}, busy, 1);
            if (scramble && i == 1) begin
                addr    = addr ^ 8'h30;
                data_wr = 8'h3C;
            end
        end
        if (l == 0) check({tag, " ack timeout"}, 0, 1);
        else if (sb.size() == 0) check({tag, " unexpected ack"}, 0, 1);
        else begin
            x = sb.pop_front();
            check({tag, " data_rd"}, data_rd, x.d);
            check({tag, " err"}, err, x.e);
            check({tag, " ack busy"}, busy, 1);
        end
    endtask

    task automatic txn(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic scramble, input string tag);
        addr    = a;
        data_wr = d;
        wr_req  = wr;
        rd_req  = !wr;
        push(wr, a, d);
        ack_wait(tag, 1'b1, scramble, lat);
        check({tag, " latency"}, lat, 3);
        rd_req = 1'b0;
        wr_req = 1'b0;
        @(negedge clk);
        check({tag, " post ack"}, mem_ack, 0);
        check({tag, " post busy"}, busy, 0);
        check({tag, " post err"}, err, 0);
        check({tag, " hold"}, data_rd, rd_model);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst data_rd", data_rd, 0);
        check("rst ack", mem_ack, 0);
        check("rst busy", busy, 0);
        check("rst err", err, 0);
        rst = 1'b1;
        @(negedge clk);
        txn(1'b1, 8'h10, 8'hA5, 1'b0, "wr10");
        txn(1'b0, 8'h10, 8'h00, 1'b0, "rd10");
        rd_req = 1'b1; wr_req = 1'b1; addr = 8'h10; data_wr = 8'hFF;
        @(negedge clk);
        check("both err", err, 1);
        check("both ack", mem_ack, 0);
        check("both busy", busy, 0);
        rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        check("both err drop", err, 0);
        txn(1'b0, 8'h10, 8'h00, 1'b0, "rd10 after both");
        txn(1'b1, 8'h48, 8'h5A, 1'b0, "wr48");
        txn(1'b0, 8'hC8, 8'h00, 1'b0, "rdC8 oor");
        txn(1'b1, 8'hC8, 8'hEE, 1'b0, "wrC8 oor");
        txn(1'b0, 8'h48, 8'h00, 1'b0, "rd48");
        txn(1'b1, 8'h20, 8'h11, 1'b0, "wr20");
        txn(1'b1, 8'h10, 8'h00, 1'b0, "wr10 clr");
        txn(1'b1, 8'h10, 8'hA5, 1'b1, "wr10 scramble");
        txn(1'b0, 8'h10, 8'h00, 1'b0, "rd10 latched");
        txn(1'b0, 8'h20, 8'h00, 1'b0, "rd20 untouched");
        txn(1'b1, 8'h30, 8'h77, 1'b0, "wr30");
        wr_req = 1'b1; addr = 8'h30; data_wr = 8'h99;
        @(negedge clk);
        check("mid busy", busy, 1);
        rst = 1'b0;
        #1;
        check("mid rst busy", busy, 0);
        check("mid rst ack", mem_ack, 0);
        check("mid rst data_rd", data_rd, 0);
        check("mid rst err", err, 0);
        wr_req = 1'b0;
        rd_model = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        txn(1'b0, 8'h30, 8'h00, 1'b0, "rd30 after rst");
        rd_req = 1'b1; addr = 8'h10;
        push(1'b0, 8'h10, 8'h00);
        push(1'b0, 8'h10, 8'h00);
        ack_wait("b2b first", 1'b1, 1'b0, lat);
        check("b2b first latency", lat, 3);
        ack_wait("b2b second", 1'b0, 1'b0, lat);
        check("b2b second spacing", lat, 4);
        rd_req = 1'b0;
        @(negedge clk);
        check("b2b end busy", busy, 0);
        check("b2b end ack", mem_ack, 0);
        check("sb empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
